// File: rtl/board_pkg.sv
// Shared definitions for the board view transform slice.
//   ROT_*           : two-bit rotation encodings (quarter turns, clockwise)
//   DEFAULT_BOARD_N : standard board dimension in squares
//   coord_t         : coordinate type at the default port width
//   flip_state_t    : auto-flip delay FSM states
//   rot_add         : modulo-4 sum of two rotations
package board_pkg;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    localparam int DEFAULT_BOARD_N = 8;

    typedef logic [7:0] coord_t;

    typedef enum logic {
        FLIP_IDLE,
        FLIP_COUNT
    } flip_state_t;

    function automatic logic [1:0] rot_add(input logic [1:0] a, input logic [1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/board_coord_map.sv
// Purely combinational mirror + rotate + out-of-board check.
//   x, y         : source coordinate
//   rot, mirror  : view mode to apply
//   map_x, map_y : mapped coordinate (source passed through when out of board)
//   oob          : source coordinate lies outside the board
// INVERSE=0 maps logical->view (mirror, then rotate by rot).
// INVERSE=1 maps view->logical (rotate by (4-rot) mod 4, then mirror).
module board_coord_map
    import board_pkg::*;
#(
    parameter int BOARD_N = DEFAULT_BOARD_N,
    parameter int COORD_W = 8,
    parameter bit INVERSE = 1'b0
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         rot,
    input  logic               mirror,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    output logic               oob
);

    localparam logic [COORD_W-1:0] N_SQ  = COORD_W'(BOARD_N);
    localparam logic [COORD_W-1:0] N_MAX = COORD_W'(BOARD_N - 1);

    logic [1:0]         eff_rot;
    logic [COORD_W-1:0] pre_x;
    logic [COORD_W-1:0] rot_x;
    logic [COORD_W-1:0] rot_y;

    always_comb begin
        oob     = (x >= N_SQ) || (y >= N_SQ);
        eff_rot = INVERSE ? (2'd0 - rot) : rot;
        pre_x   = (!INVERSE && mirror) ? (N_MAX - x) : x;

        case (eff_rot)
            ROT_90:  begin rot_x = N_MAX - y;     rot_y = pre_x;         end
            ROT_180: begin rot_x = N_MAX - pre_x; rot_y = N_MAX - y;     end
            ROT_270: begin rot_x = y;             rot_y = N_MAX - pre_x; end
            default: begin rot_x = pre_x;         rot_y = y;             end
        endcase

        if (oob) begin
            map_x = x;
            map_y = y;
        end else begin
            map_x = (INVERSE && mirror) ? (N_MAX - rot_x) : rot_x;
            map_y = rot_y;
        end
    end

endmodule

// File: rtl/board_view_transform.sv
// Registered logical->view coordinate transform for an N x N board.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_x/in_y   : logical coordinate input handshake
//   out_valid/out_ready/out_x/out_y/out_oob : view coordinate output (1-cycle latency)
//   mode_rot/mode_mirror/mode_load: user view mode, latched into a pending register
//   auto_flip_en/side_black       : automatic 180-degree flip for black to move
//   frame_start                   : frame boundary; the only point where modes commit
//   active_rot/active_mirror      : mode currently applied to accepted inputs
//   flip_busy                     : auto-flip delay countdown in progress
module board_view_transform
    import board_pkg::*;
#(
    parameter int BOARD_N    = DEFAULT_BOARD_N,
    parameter int COORD_W    = 8,
    parameter int FLIP_DELAY = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_oob,
    input  logic [1:0]         mode_rot,
    input  logic               mode_mirror,
    input  logic               mode_load,
    input  logic               auto_flip_en,
    input  logic               side_black,
    input  logic               frame_start,
    output logic [1:0]         active_rot,
    output logic               active_mirror,
    output logic               flip_busy
);

    localparam int CNT_W = (FLIP_DELAY > 0) ? $clog2(FLIP_DELAY + 1) : 1;

    logic [1:0]         pending_rot;
    logic               pending_mirror;
    logic               pending_flag;

    flip_state_t        flip_state;
    logic [CNT_W-1:0]   flip_cnt;
    logic               flip_target;
    logic               flip_ready;
    logic               flip_side_black;
    logic               next_flip_side;
    logic               side_prev;
    logic               side_seen;

    logic [COORD_W-1:0] map_x;
    logic [COORD_W-1:0] map_y;
    logic               map_oob;

    board_coord_map #(
        .BOARD_N (BOARD_N),
        .COORD_W (COORD_W),
        .INVERSE (1'b0)
    ) u_map (
        .x      (in_x),
        .y      (in_y),
        .rot    (active_rot),
        .mirror (active_mirror),
        .map_x  (map_x),
        .map_y  (map_y),
        .oob    (map_oob)
    );

    assign in_ready  = !out_valid || out_ready;
    assign flip_busy = (flip_state == FLIP_COUNT);

    // Flip side that a frame_start this cycle would commit.
    always_comb begin
        next_flip_side = flip_ready ? flip_target : flip_side_black;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_oob   <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_x     <= map_x;
            out_y     <= map_y;
            out_oob   <= map_oob;
        end else if (in_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Mode pending/commit and auto-flip delay FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_rot     <= ROT_0;
            pending_mirror  <= 1'b0;
            pending_flag    <= 1'b0;
            active_rot      <= ROT_0;
            active_mirror   <= 1'b0;
            flip_state      <= FLIP_IDLE;
            flip_cnt        <= '0;
            flip_target     <= 1'b0;
            flip_ready      <= 1'b0;
            flip_side_black <= 1'b0;
            side_prev       <= 1'b0;
            side_seen       <= 1'b0;
        end else begin
            // Commit reads the pre-update pending/flip values, so a same-cycle
            // mode_load or newly-ready target waits for the next frame.
            if (frame_start) begin
                active_rot      <= rot_add(pending_rot,
                                           (auto_flip_en && next_flip_side) ? ROT_180 : ROT_0);
                flip_side_black <= next_flip_side;
                flip_ready      <= 1'b0;
                pending_flag    <= 1'b0;
                if (pending_flag) begin
                    active_mirror <= pending_mirror;
                end
            end

            if (mode_load) begin
                pending_rot    <= mode_rot;
                pending_mirror <= mode_mirror;
                pending_flag   <= 1'b1;
            end

            side_prev <= side_black;
            if (!side_seen) begin
                // First sample after reset is only a baseline.
                side_seen <= 1'b1;
            end else if (side_black != side_prev) begin
                // A newer side supersedes any target not yet committed.
                flip_target <= side_black;
                flip_cnt    <= CNT_W'(FLIP_DELAY);
                if (FLIP_DELAY == 0) begin
                    flip_ready <= 1'b1;
                    flip_state <= FLIP_IDLE;
                end else begin
                    flip_ready <= 1'b0;
                    flip_state <= FLIP_COUNT;
                end
            end else if (flip_state == FLIP_COUNT) begin
                // Ready on the cycle the count would reach zero: busy for
                // exactly FLIP_DELAY cycles.
                if (flip_cnt <= CNT_W'(1)) begin
                    flip_cnt   <= '0;
                    flip_ready <= 1'b1;
                    flip_state <= FLIP_IDLE;
                end else begin
                    flip_cnt <= flip_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_view_transform.sv
module tb_board_view_transform;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic       out_oob;
    logic [1:0] mode_rot;
    logic       mode_mirror;
    logic       mode_load;
    logic       auto_flip_en;
    logic       side_black;
    logic       frame_start;
    logic [1:0] active_rot;
    logic       active_mirror;
    logic       flip_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    board_view_transform #(
        .BOARD_N    (8),
        .COORD_W    (8),
        .FLIP_DELAY (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_oob       (out_oob),
        .mode_rot      (mode_rot),
        .mode_mirror   (mode_mirror),
        .mode_load     (mode_load),
        .auto_flip_en  (auto_flip_en),
        .side_black    (side_black),
        .frame_start   (frame_start),
        .active_rot    (active_rot),
        .active_mirror (active_mirror),
        .flip_busy     (flip_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] r, input logic m);
        mode_rot    = r;
        mode_mirror = m;
        mode_load   = 1'b1;
        tick();
        mode_load   = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({out_valid, out_x, out_y, out_oob} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_out: got v=%0b x=%0d y=%0d oob=%0b, want all 0", out_valid, out_x, out_y, out_oob);
        end
        tests_run++;
        if ({active_rot, active_mirror, flip_busy} !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_mode: got rot=%0d mir=%0b busy=%0b, want 0", active_rot, active_mirror, flip_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        send(8'd1, 8'd2);
        tests_run++;
        if ({out_valid, out_x, out_y, out_oob} !== {1'b1, 8'd1, 8'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL rot0_12: got v=%0b (%0d,%0d) oob=%0b, want v=1 (1,2) oob=0", out_valid, out_x, out_y, out_oob);
        end
        tests_run++;
        if (in_ready !== 1'b1 || active_rot !== 2'd0) begin
            tests_failed++;
            $display("FAIL rot0_ready: got in_ready=%0b rot=%0d, want 1 0", in_ready, active_rot);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_clear: got out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_rotations();
        set_mode(2'd1, 1'b0);
        tests_run++;
        if (active_rot !== 2'd1) begin
            tests_failed++;
            $display("FAIL rot90_commit: got %0d, want 1", active_rot);
        end
        send(8'd1, 8'd2);
        tests_run++;
        if ({out_x, out_y} !== {8'd5, 8'd1}) begin
            tests_failed++;
            $display("FAIL rot90_12: got (%0d,%0d), want (5,1)", out_x, out_y);
        end
        set_mode(2'd3, 1'b0);
        send(8'd1, 8'd2);
        tests_run++;
        if ({out_x, out_y} !== {8'd2, 8'd6}) begin
            tests_failed++;
            $display("FAIL rot270_12: got (%0d,%0d), want (2,6)", out_x, out_y);
        end
        set_mode(2'd2, 1'b1);
        send(8'd1, 8'd2);
        tests_run++;
        if ({out_x, out_y, active_mirror} !== {8'd1, 8'd5, 1'b1}) begin
            tests_failed++;
            $display("FAIL rot180m_12: got (%0d,%0d) mir=%0b, want (1,5) mir=1", out_x, out_y, active_mirror);
        end
        // mode_load together with frame_start: old pending value commits
        mode_rot    = 2'd1;
        mode_mirror = 1'b0;
        mode_load   = 1'b1;
        frame_start = 1'b1;
        tick();
        mode_load   = 1'b0;
        frame_start = 1'b0;
        tests_run++;
        if ({active_rot, active_mirror} !== {2'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL same_cycle_load: got rot=%0d mir=%0b, want rot=2 mir=1", active_rot, active_mirror);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if ({active_rot, active_mirror} !== {2'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL next_frame_load: got rot=%0d mir=%0b, want rot=1 mir=0", active_rot, active_mirror);
        end
    endtask

    task automatic test_auto_flip();
        set_mode(2'd0, 1'b0);
        auto_flip_en = 1'b1;
        side_black   = 1'b1;
        tick();
        tests_run++;
        if (flip_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_c1: got %0b, want 1", flip_busy);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (flip_busy !== 1'b1 || active_rot !== 2'd0) begin
            tests_failed++;
            $display("FAIL busy_c2_frame: got busy=%0b rot=%0d, want busy=1 rot=0", flip_busy, active_rot);
        end
        tick();
        tick();
        tests_run++;
        if (flip_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_c4: got %0b, want 1", flip_busy);
        end
        tick();
        tests_run++;
        if (flip_busy !== 1'b0 || active_rot !== 2'd0) begin
            tests_failed++;
            $display("FAIL busy_done: got busy=%0b rot=%0d, want busy=0 rot=0", flip_busy, active_rot);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (active_rot !== 2'd2) begin
            tests_failed++;
            $display("FAIL flip_commit: got rot=%0d, want 2", active_rot);
        end
        send(8'd0, 8'd0);
        tests_run++;
        if ({out_x, out_y} !== {8'd7, 8'd7}) begin
            tests_failed++;
            $display("FAIL flip_00: got (%0d,%0d), want (7,7)", out_x, out_y);
        end
        auto_flip_en = 1'b0;
        tick();
        tests_run++;
        if (active_rot !== 2'd2) begin
            tests_failed++;
            $display("FAIL flip_off_hold: got rot=%0d, want 2", active_rot);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (active_rot !== 2'd0) begin
            tests_failed++;
            $display("FAIL flip_off_frame: got rot=%0d, want 0", active_rot);
        end
    endtask

    task automatic test_backpressure();
        tick();
        out_ready = 1'b0;
        send(8'd3, 8'd4);
        in_valid = 1'b1;
        in_x     = 8'd5;
        in_y     = 8'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({out_valid, out_x, out_y, in_ready} !== {1'b1, 8'd3, 8'd4, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d: got v=%0b (%0d,%0d) in_ready=%0b, want v=1 (3,4) in_ready=0",
                         i, out_valid, out_x, out_y, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: got %0b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_x, out_y} !== {1'b1, 8'd5, 8'd6}) begin
            tests_failed++;
            $display("FAIL release_next: got v=%0b (%0d,%0d), want v=1 (5,6)", out_valid, out_x, out_y);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_duplicate: got out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_oob();
        send(8'd8, 8'd3);
        tests_run++;
        if ({out_x, out_y, out_oob} !== {8'd8, 8'd3, 1'b1}) begin
            tests_failed++;
            $display("FAIL oob_83: got (%0d,%0d) oob=%0b, want (8,3) oob=1", out_x, out_y, out_oob);
        end
        send(8'd255, 8'd0);
        tests_run++;
        if ({out_x, out_y, out_oob} !== {8'd255, 8'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL oob_255: got (%0d,%0d) oob=%0b, want (255,0) oob=1", out_x, out_y, out_oob);
        end
        // input accepted in the commit cycle uses the old (rot0) mode
        mode_rot    = 2'd1;
        mode_mirror = 1'b0;
        mode_load   = 1'b1;
        tick();
        mode_load   = 1'b0;
        frame_start = 1'b1;
        send(8'd1, 8'd2);
        frame_start = 1'b0;
        tests_run++;
        if ({out_x, out_y, active_rot} !== {8'd1, 8'd2, 2'd1}) begin
            tests_failed++;
            $display("FAIL commit_cycle: got (%0d,%0d) rot=%0d, want (1,2) rot=1", out_x, out_y, active_rot);
        end
        send(8'd7, 8'd7);
        tests_run++;
        if ({out_x, out_y, out_oob} !== {8'd0, 8'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL rot90_77: got (%0d,%0d) oob=%0b, want (0,7) oob=0", out_x, out_y, out_oob);
        end
        send(8'd3, 8'd8);
        tests_run++;
        if ({out_x, out_y, out_oob} !== {8'd3, 8'd8, 1'b1}) begin
            tests_failed++;
            $display("FAIL rot90_oob: got (%0d,%0d) oob=%0b, want (3,8) oob=1", out_x, out_y, out_oob);
        end
    endtask

    task automatic test_reset_mid_countdown();
        // rot90 active, committed flip side is black from the auto-flip test
        auto_flip_en = 1'b1;
        send(8'd1, 8'd2);
        side_black = 1'b0;
        tick();
        tests_run++;
        if (flip_busy !== 1'b1 || active_rot !== 2'd1) begin
            tests_failed++;
            $display("FAIL pre_reset: got busy=%0b rot=%0d, want busy=1 rot=1", flip_busy, active_rot);
        end
        side_black = 1'b1;
        rst = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_x, out_y, out_oob, active_rot, active_mirror, flip_busy} !== 22'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%0b (%0d,%0d) oob=%0b rot=%0d mir=%0b busy=%0b, want all 0",
                     out_valid, out_x, out_y, out_oob, active_rot, active_mirror, flip_busy);
        end
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (flip_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL baseline: got busy=%0b, want 0", flip_busy);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (active_rot !== 2'd0) begin
            tests_failed++;
            $display("FAIL stale_flip: got rot=%0d, want 0", active_rot);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        out_ready    = 1'b1;
        mode_rot     = 2'd0;
        mode_mirror  = 1'b0;
        mode_load    = 1'b0;
        auto_flip_en = 1'b0;
        side_black   = 1'b0;
        frame_start  = 1'b0;

        test_reset();
        test_passthrough();
        test_rotations();
        test_auto_flip();
        test_backpressure();
        test_oob();
        test_reset_mid_countdown();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
